// File: rtl/wm_mac_pkg.sv
// Shared types and default widths for the Wallace-multiplier accumulate stage.
package wm_mac_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    OUT  = 2'd2
  } mac_state_e;

  localparam int unsigned PROD_W_DEF = 65;
  localparam int unsigned ACC_W_DEF  = 80;
  localparam int unsigned CNT_W_DEF  = 16;

endpackage

// File: rtl/wm_mac_add.sv
// W-bit adder with carry-out, built from per-bit generate/propagate terms.
module wm_mac_add #(
  parameter int unsigned W = 80
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic [W-1:0] sum_o,
  output logic         cout_o
);

  logic [W-1:0] g;
  logic [W-1:0] p;
  logic [W:0]   c;

  always_comb begin
    g = a_i & b_i;
    p = a_i ^ b_i;
    c = '0;
    // a carry into bit i+1 is generated at i, or propagated through i
    for (int unsigned i = 0; i < W; i++) begin
      c[i+1] = g[i] | (p[i] & c[i]);
    end
    sum_o  = p ^ c[W-1:0];
    cout_o = c[W];
  end

endmodule

// File: rtl/wm_mac_acc.sv
// Dot-product accumulate stage behind the 32x32 Wallace multiplier.
// Optional macro WM_MAC_SAT_EN: clamp the accumulator to all-ones on carry-out.
module wm_mac_acc
  import wm_mac_pkg::*;
#(
  parameter int unsigned PROD_W = PROD_W_DEF,
  parameter int unsigned ACC_W  = ACC_W_DEF,
  parameter int unsigned CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              prod_valid,
  output logic              prod_ready,
  input  logic [PROD_W-1:0] prod,
  input  logic              prod_last,
  input  logic              abort,
  output logic              result_valid,
  input  logic              result_ready,
  output logic [ACC_W-1:0]  result,
  output logic [CNT_W-1:0]  term_count,
  output logic              ovf
);

  mac_state_e       state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;

  logic [ACC_W-1:0] prod_ext;
  logic [ACC_W-1:0] add_sum;
  logic             add_cout;
  logic             accept;

  assign prod_ext = ACC_W'(prod);

  wm_mac_add #(.W(ACC_W)) u_add (
    .a_i    (acc_q),
    .b_i    (prod_ext),
    .sum_o  (add_sum),
    .cout_o (add_cout)
  );

  assign prod_ready   = !rst && !abort && (state_q == IDLE || state_q == ACC);
  assign accept       = prod_valid && prod_ready;
  assign result_valid = (state_q == OUT);
  assign result       = acc_q;
  assign term_count   = cnt_q;
  assign ovf          = ovf_q;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    if (abort) begin
      state_d = IDLE;
      acc_d   = '0;
      cnt_d   = '0;
      ovf_d   = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            acc_d   = prod_ext;
            cnt_d   = CNT_W'(1);
            ovf_d   = 1'b0;
            state_d = prod_last ? OUT : ACC;
          end
        end
        ACC: begin
          if (accept) begin
`ifdef WM_MAC_SAT_EN
            acc_d = add_cout ? '1 : add_sum;
`else
            acc_d = add_sum;
`endif
            ovf_d = ovf_q | add_cout;
            cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
            if (prod_last) state_d = OUT;
          end
        end
        OUT: begin
          if (result_ready) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

endmodule

// File: tb/tb_wm_mac_acc.sv
// Bench for wm_mac_acc: three width configurations driven in lockstep against a run-sum model.
module tb_wm_mac_acc;

`ifdef WM_MAC_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        prod_valid;
  logic [64:0] prod;
  logic        prod_last;
  logic        abort;
  logic        result_ready;

  logic        rdy0, rdy1, rdy2;
  logic        rv0, rv1, rv2;
  logic [79:0] res0;
  logic [64:0] res1;
  logic [79:0] res2;
  logic [15:0] cnt0, cnt1;
  logic [1:0]  cnt2;
  logic        ovf0, ovf1, ovf2;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  logic [64:0] run_q[$];
  bit          out_pending;

  always #5 clk = ~clk;

  wm_mac_acc dut0 (
    .clk(clk), .rst(rst), .prod_valid(prod_valid), .prod_ready(rdy0), .prod(prod),
    .prod_last(prod_last), .abort(abort), .result_valid(rv0), .result_ready(result_ready),
    .result(res0), .term_count(cnt0), .ovf(ovf0));

  wm_mac_acc #(.ACC_W(65)) dut1 (
    .clk(clk), .rst(rst), .prod_valid(prod_valid), .prod_ready(rdy1), .prod(prod),
    .prod_last(prod_last), .abort(abort), .result_valid(rv1), .result_ready(result_ready),
    .result(res1), .term_count(cnt1), .ovf(ovf1));

  wm_mac_acc #(.CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .prod_valid(prod_valid), .prod_ready(rdy2), .prod(prod),
    .prod_last(prod_last), .abort(abort), .result_valid(rv2), .result_ready(result_ready),
    .result(res2), .term_count(cnt2), .ovf(ovf2));

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Sum of the current run reduced to w bits, with wrap or clamp on overflow.
  function automatic logic [128:0] model_run(input int unsigned w);
    logic [127:0] s, mask;
    logic         o;
    mask = (128'd1 << w) - 128'd1;
    s = '0;
    o = 1'b0;
    foreach (run_q[i]) begin
      s = s + {63'd0, run_q[i]};
      if ((s & ~mask) != '0) begin
        o = 1'b1;
        s = SAT ? mask : (s & mask);
      end
    end
    return {o, s};
  endfunction

  function automatic logic [127:0] model_cnt(input int unsigned cw);
    int unsigned mx;
    mx = (1 << cw) - 1;
    return (run_q.size() > mx) ? 128'(mx) : 128'(run_q.size());
  endfunction

  task automatic check_results();
    logic [128:0] m;
    m = model_run(80);
    check("res_d0", res0, m[127:0]);
    check("ovf_d0", ovf0, m[128]);
    check("cnt_d0", cnt0, model_cnt(16));
    m = model_run(65);
    check("res_d1", res1, m[127:0]);
    check("ovf_d1", ovf1, m[128]);
    m = model_run(80);
    check("res_d2", res2, m[127:0]);
    check("cnt_d2", cnt2, model_cnt(2));
  endtask

  // One clock: drive inputs, check before the edge, advance model, step past the edge.
  task automatic cycle(input bit v, input logic [64:0] p, input bit last, input bit ab, input bit rr);
    bit exp_ready;
    prod_valid = v; prod = p; prod_last = last; abort = ab; result_ready = rr;
    #1;
    exp_ready = !out_pending && !ab;
    check("prod_ready_d0", rdy0, exp_ready);
    check("prod_ready_d1", rdy1, exp_ready);
    check("prod_ready_d2", rdy2, exp_ready);
    check("result_valid", {rv0, rv1, rv2}, {3{out_pending}});
    if (out_pending) check_results();
    if (ab) begin
      run_q.delete();
      out_pending = 1'b0;
    end else if (out_pending) begin
      if (rr) begin
        run_q.delete();
        out_pending = 1'b0;
      end
    end else if (v) begin
      run_q.push_back(p);
      if (last) out_pending = 1'b1;
    end
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; prod_valid = 1'b1; prod = 65'd55; prod_last = 1'b1; abort = 1'b0; result_ready = 1'b0;
    #1;
    check("rst_ready", {rdy0, rdy1, rdy2}, 3'b000);
    @(posedge clk); #1;
    rst = 1'b0;
    run_q.delete();
    out_pending = 1'b0;
    check("rst_valid", {rv0, rv1, rv2}, 3'b000);
    check("rst_result", res0, 0);
    check("rst_result_d1", res1, 0);
    check("rst_count", cnt0, 0);
    check("rst_ovf", {ovf0, ovf1, ovf2}, 3'b000);
  endtask

  initial begin
    logic [64:0] big, rp;
    big = 65'h0_FFFF_FFFE_0000_0001;
    rst = 1'b1; prod_valid = 1'b0; prod = '0; prod_last = 1'b0; abort = 1'b0; result_ready = 1'b0;
    out_pending = 1'b0;
    do_reset();

    // basic three-term run
    cycle(1, 65'd6, 0, 0, 1);
    cycle(1, 65'd7, 0, 0, 1);
    cycle(1, 65'd8, 1, 0, 1);
    check("t1_valid", rv0, 1'b1);
    check("t1_result", res0, 21);
    check("t1_count", cnt0, 3);
    check("t1_ovf", ovf0, 0);
    cycle(0, 65'd0, 0, 0, 1);
    check("t1_idle", rv0, 1'b0);

    // single beat, consumer stalls
    cycle(1, big, 1, 0, 0);
    for (int i = 0; i < 5; i++) cycle(1, 65'd1, 0, 0, 0);
    check("t2_result", res0, big);
    check("t2_count", cnt0, 1);
    cycle(0, 65'd0, 0, 0, 1);

    // overflow in the 65-bit accumulator
    cycle(1, big, 0, 0, 0);
    cycle(1, big, 0, 0, 0);
    cycle(1, big, 1, 0, 0);
    check("t3_result_d1", res1, SAT ? 128'h1_FFFF_FFFF_FFFF_FFFF : 128'h0_FFFF_FFFA_0000_0003);
    check("t3_ovf_d1", ovf1, 1);
    check("t3_ovf_d0", ovf0, 0);
    cycle(0, 65'd0, 0, 0, 1);

    // abort beats acceptance
    cycle(1, 65'd5, 0, 0, 0);
    cycle(1, 65'd9, 0, 0, 0);
    cycle(1, 65'd100, 0, 1, 0);
    check("t4_idle", rv0, 0);
    cycle(1, 65'd4, 1, 0, 0);
    check("t4_result", res0, 4);
    check("t4_count", cnt0, 1);
    cycle(0, 65'd0, 0, 0, 1);

    // no same-cycle bypass after handoff
    cycle(1, 65'd2, 1, 0, 0);
    cycle(1, 65'd3, 1, 0, 1);
    cycle(1, 65'd3, 1, 0, 0);
    check("t5_result", res0, 3);
    check("t5_valid", rv0, 1);
    cycle(0, 65'd0, 0, 0, 1);

    // term counter saturates in the 2-bit instance
    for (int i = 0; i < 5; i++) cycle(1, 65'd1, (i == 4), 0, 0);
    check("t6_count_d2", cnt2, 3);
    check("t6_result_d2", res2, 5);
    check("t6_count_d0", cnt0, 5);
    cycle(0, 65'd0, 0, 0, 1);

    // abort while a result is held
    cycle(1, 65'd11, 1, 0, 0);
    cycle(0, 65'd0, 0, 1, 1);
    check("abort_out", rv0, 0);

    // reset mid-run
    cycle(1, 65'd7, 0, 0, 0);
    do_reset();

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(3, 0) == 0) rp = {1'b0, 32'hFFFF_FFFF, 32'($urandom)};
      else rp = {1'($urandom), 32'($urandom), 32'($urandom)};
      cycle($urandom_range(3, 0) != 0, rp, $urandom_range(5, 0) == 0,
            $urandom_range(24, 0) == 0, $urandom_range(1, 0) == 1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
